// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU: registered fetch/load read ports, one write port,
// a word-addressed block RAM and an MMIO window (TX byte FIFO, status, 32-bit timer).
module cpu_mem_responder #(
  parameter int unsigned ADDR_W     = 14,
  parameter logic [15:0] MMIO_BASE  = 16'hFFF0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic [15:0] mem_read0_addr,
  output logic [15:0] mem_read0_data,
  input  logic [15:0] mem_read1_addr,
  output logic [15:0] mem_read1_data,
  input  logic        mem_write_en,
  input  logic [15:0] mem_write_addr,
  input  logic [15:0] mem_write_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RamWords = 2 ** ADDR_W;
  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW     = PtrW + 1;

  localparam logic [15:0] OffTxData  = 16'd0;
  localparam logic [15:0] OffStatus  = 16'd1;
  localparam logic [15:0] OffTimerLo = 16'd2;
  localparam logic [15:0] OffTimerHi = 16'd3;

  function automatic logic is_mmio(input logic [15:0] addr);
    return addr >= MMIO_BASE;
  endfunction

  function automatic logic is_ram(input logic [15:0] addr);
    return (addr < MMIO_BASE) && (32'(addr) < RamWords);
  endfunction

  // ---------------------------------------------------------------------------
  // Write decode (everything is suppressed during reset)
  // ---------------------------------------------------------------------------
  logic        wr_ram;
  logic        wr_mmio;
  logic [15:0] wr_off;
  logic        push;
  logic        status_wr;
  logic        timer_clr;

  assign wr_ram    = mem_write_en && !rst && is_ram(mem_write_addr);
  assign wr_mmio   = mem_write_en && !rst && is_mmio(mem_write_addr);
  assign wr_off    = mem_write_addr - MMIO_BASE;
  assign push      = wr_mmio && (wr_off == OffTxData);
  assign status_wr = wr_mmio && (wr_off == OffStatus);
  assign timer_clr = wr_mmio && (wr_off == OffTimerLo);

  // ---------------------------------------------------------------------------
  // Block RAM
  // ---------------------------------------------------------------------------
  logic [15:0] ram [RamWords];

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[mem_write_addr[ADDR_W-1:0]] <= mem_write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            ovf_q;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push_ok;
  logic            push_drop;

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = !empty && tx_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= mem_write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CntW'(1);
      end
      if (push_drop) begin
        ovf_q <= 1'b1;
      end else if (status_wr && mem_write_data[2]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr_q];

  logic [3:0]  count4;
  logic [15:0] status;

  assign count4 = 4'(count_q);
  assign status = {8'h00, count4, 1'b0, ovf_q, full, empty};

  // ---------------------------------------------------------------------------
  // Cycle timer and high-half snapshot
  // ---------------------------------------------------------------------------
  logic [31:0] timer_q;
  logic [31:0] timer_view;
  logic [15:0] snap_q;
  logic        snap_load;

  // Reads report the count including the sampling edge, so a read N edges after a
  // clear returns N; the snapshot captures the high half of that same value.
  assign timer_view = timer_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      snap_q  <= '0;
    end else begin
      timer_q <= timer_clr ? 32'd0 : timer_q + 32'd1;
      if (snap_load) begin
        snap_q <= timer_view[31:16];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: write-first bypass on RAM hits, registered outputs
  // ---------------------------------------------------------------------------
  logic [15:0] rd0_next;
  logic [15:0] rd1_next;
  logic [15:0] rd1_off;
  logic [15:0] rd0_q, rd1_q;

  assign rd1_off = mem_read1_addr - MMIO_BASE;

  always_comb begin
    rd0_next = '0;
    if (is_ram(mem_read0_addr)) begin
      rd0_next = (wr_ram && (mem_write_addr == mem_read0_addr)) ? mem_write_data
                                                               : ram[mem_read0_addr[ADDR_W-1:0]];
    end
  end

  always_comb begin
    rd1_next  = '0;
    snap_load = 1'b0;
    if (is_mmio(mem_read1_addr)) begin
      case (rd1_off)
        OffStatus:  rd1_next = status;
        OffTimerLo: begin
          rd1_next  = timer_view[15:0];
          snap_load = mem_read_en;
        end
        OffTimerHi: rd1_next = snap_q;
        default:    rd1_next = '0;
      endcase
    end else if (is_ram(mem_read1_addr)) begin
      rd1_next = (wr_ram && (mem_write_addr == mem_read1_addr)) ? mem_write_data
                                                               : ram[mem_read1_addr[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      rd0_q <= rd0_next;
      if (mem_read_en) begin
        rd1_q <= rd1_next;
      end
    end
  end

  assign mem_read0_data = rd0_q;
  assign mem_read1_data = rd1_q;

endmodule
